// File: rtl/labs_search_wb.sv
// Wishbone-attached exhaustive search for a low-autocorrelation binary sequence.
// Scores every candidate in [SEQ_START, SEQ_END] by sidelobe energy and keeps the earliest minimum.
module labs_search_wb #(
  parameter int SEQ_WIDTH = 16,
  parameter int E_WIDTH   = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  input  logic [127:0] la_data_in,
  output logic [127:0] la_data_out,
  input  logic [127:0] la_oenb,
  output logic [2:0]   irq
);

  localparam int KW = $clog2(SEQ_WIDTH);
  localparam logic [E_WIDTH-1:0] E_MAX = '1;

  typedef enum logic [2:0] {IDLE, LOAD, CORR, CMP, DONE} state_t;

  state_t                 state;
  logic                   ien, done, aborted, ovf;
  logic [SEQ_WIDTH-1:0]   seq_start, seq_end, end_l, cur, seq_p0;
  logic [KW-1:0]          k;
  logic [E_WIDTH-1:0]     acc_p1, best_e;
  logic [SEQ_WIDTH-1:0]   best_seq;
  logic [31:0]            count;
  logic [31:0]            rd_data;
  logic                   busy, acc_cyc, wr, start_req, abort_req;
  logic [2:0]             reg_sel;
  logic signed [7:0]      c_k;
  logic [15:0]            c_sq;
  logic [E_WIDTH:0]       sum;
  logic                   unused_bits;

  // C_k: matching pairs minus mismatching pairs over the L-k overlapping positions.
  function automatic logic signed [7:0] corr_term(input logic [SEQ_WIDTH-1:0] s,
                                                  input logic [KW-1:0] kk);
    logic [SEQ_WIDTH-1:0] x;
    logic [7:0]           pc;
    x  = (s ^ (s >> kk)) & ({SEQ_WIDTH{1'b1}} >> kk);
    pc = '0;
    for (int i = 0; i < SEQ_WIDTH; i++) pc = pc + {7'b0, x[i]};
    return $signed(8'(SEQ_WIDTH) - 8'(kk) - (pc << 1));
  endfunction

  function automatic logic [15:0] square(input logic signed [7:0] c);
    logic [7:0] m;
    m = c[7] ? 8'(-c) : 8'(c);
    return m * m;
  endfunction

  // Returns {overflow, saturated sum}.
  function automatic logic [E_WIDTH:0] sat_add(input logic [E_WIDTH-1:0] a,
                                               input logic [15:0] b);
    logic [E_WIDTH+16:0] w;
    w = {17'b0, a} + {{(E_WIDTH+1){1'b0}}, b};
    if (w > {17'b0, E_MAX}) return {1'b1, E_MAX};
    return {1'b0, w[E_WIDTH-1:0]};
  endfunction

  assign acc_cyc   = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr        = acc_cyc & wbs_we_i;
  assign reg_sel   = wbs_adr_i[4:2];
  assign start_req = wr && reg_sel == 3'd0 && wbs_dat_i[0] && !wbs_dat_i[1];
  assign abort_req = wr && reg_sel == 3'd0 && wbs_dat_i[1];
  assign busy      = state inside {LOAD, CORR, CMP};

  assign c_k  = corr_term(seq_p0, k);
  assign c_sq = square(c_k);
  assign sum  = sat_add(acc_p1, c_sq);

  assign irq         = {2'b0, done & ien};
  assign la_data_out = {62'b0, done, busy, 32'b0, 32'(cur)};
  assign unused_bits = ^{wbs_sel_i, la_data_in, la_oenb, wbs_adr_i[31:5], wbs_adr_i[1:0], wbs_dat_i};

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      3'd0:    rd_data[2] = ien;
      3'd1:    rd_data[3:0] = {ovf, aborted, done, busy};
      3'd2:    rd_data = 32'(seq_start);
      3'd3:    rd_data = 32'(seq_end);
      3'd4:    rd_data = 32'(best_e);
      3'd5:    rd_data = 32'(best_seq);
      3'd6:    rd_data = count;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ien       <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      ovf       <= 1'b0;
      seq_start <= '0;
      seq_end   <= '0;
      end_l     <= '0;
      cur       <= '0;
      seq_p0    <= '0;
      k         <= '0;
      acc_p1    <= '0;
      best_e    <= E_MAX;
      best_seq  <= '0;
      count     <= '0;
    end else begin
      wbs_ack_o <= acc_cyc;
      if (acc_cyc) wbs_dat_o <= rd_data;
      if (wr) begin
        case (reg_sel)
          3'd0:    ien       <= wbs_dat_i[2];
          3'd2:    seq_start <= wbs_dat_i[SEQ_WIDTH-1:0];
          3'd3:    seq_end   <= wbs_dat_i[SEQ_WIDTH-1:0];
          default: ;
        endcase
      end

      if (busy && abort_req) begin
        state   <= IDLE;
        aborted <= 1'b1;
        done    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_req) begin
            best_e   <= E_MAX;
            best_seq <= '0;
            count    <= '0;
            aborted  <= 1'b0;
            ovf      <= 1'b0;
            cur      <= seq_start;
            end_l    <= seq_end;
            done     <= seq_start > seq_end;
            state    <= (seq_start > seq_end) ? DONE : LOAD;
          end
          // stage p0: candidate latched, energy accumulator cleared
          LOAD: begin
            seq_p0 <= cur;
            acc_p1 <= '0;
            k      <= KW'(1);
            state  <= CORR;
          end
          // stage p1: one lag per cycle folded into the saturating energy sum
          CORR: begin
            acc_p1 <= sum[E_WIDTH-1:0];
            if (sum[E_WIDTH]) ovf <= 1'b1;
            if (k == KW'(SEQ_WIDTH - 1)) state <= CMP;
            else k <= k + KW'(1);
          end
          // stage p2: compare against best, then advance or finish
          CMP: begin
            count <= count + 32'd1;
            if (acc_p1 < best_e) begin
              best_e   <= acc_p1;
              best_seq <= seq_p0;
            end
            if (seq_p0 == end_l) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              cur   <= cur + SEQ_WIDTH'(1);
              state <= LOAD;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_labs_search_wb.sv
// Directed bench for labs_search_wb at L=4, with a second E_WIDTH=3 copy sharing the bus
// to exercise energy saturation.
module tb_labs_search_wb;

  logic         clk = 1'b0;
  logic         rst, stb, cyc, we;
  logic [3:0]   sel;
  logic [31:0]  adr, dat_i;
  logic [127:0] la_in, la_oenb;
  logic [31:0]  dat0, dat1;
  logic         ack0, ack1;
  logic [127:0] la0, la1;
  logic [2:0]   irq0, irq1;
  int           n_checks = 0;
  int           n_fail   = 0;

  localparam logic [31:0] A_CTRL = 32'h00, A_STAT = 32'h04, A_START = 32'h08, A_END = 32'h0C,
                          A_BE = 32'h10, A_BS = 32'h14, A_CNT = 32'h18, A_RSV = 32'h1C;

  always #5 clk = ~clk;

  labs_search_wb #(.SEQ_WIDTH(4), .E_WIDTH(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack0), .wbs_dat_o(dat0),
    .la_data_in(la_in), .la_data_out(la0), .la_oenb(la_oenb), .irq(irq0));

  labs_search_wb #(.SEQ_WIDTH(4), .E_WIDTH(3)) dut_e3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack1), .wbs_dat_o(dat1),
    .la_data_in(la_in), .la_data_out(la1), .la_oenb(la_oenb), .irq(irq1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r0, output logic [31:0] r1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    r0 = dat0;
    r1 = dat1;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r0, r1;
    wb_read(a, r0, r1);
    chk(tag, r0, exp);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (la0[64] && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int          n;
    logic [31:0] r0, r1;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
    adr = '0; dat_i = '0; la_in = '0; la_oenb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_la_nonzero", 32'(la0 != '0), 32'd0);
    chk("rst_ack", 32'(ack0), 32'd0);
    chk("rst_dat", dat0, 32'd0);
    chk("rst_irq", 32'(irq0), 32'd0);
    rd_chk("rst_status", A_STAT, 32'h0);
    wb_read(A_BE, r0, r1);
    chk("rst_best_e", r0, 32'hFFFF);
    chk("rst_best_e_e3", r1, 32'h7);

    // Register access: width masking, address aliasing, reserved slot, ack shape
    wb_write(A_START, 32'hFFFF_FFF5);
    rd_chk("start_mask", A_START, 32'h5);
    wb_write(32'h0000_100C, 32'hA);
    rd_chk("end_alias", A_END, 32'hA);
    wb_write(A_RSV, 32'h1234);
    rd_chk("reserved", A_RSV, 32'h0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CTRL;
    @(posedge clk);
    @(negedge clk);
    chk("ack_high", 32'(ack0), 32'd1);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("ack_low", 32'(ack0), 32'd0);

    // Full sweep 0..15
    wb_write(A_START, 32'd0);
    wb_write(A_END, 32'd15);
    wb_write(A_CTRL, 32'h1);
    busy_len(n);
    chk("full_busy", 32'(n), 32'd80);
    chk("full_done_la", 32'(la0[65]), 32'd1);
    rd_chk("full_status", A_STAT, 32'h2);
    rd_chk("full_best_e", A_BE, 32'd2);
    rd_chk("full_best_seq", A_BS, 32'd1);
    rd_chk("full_count", A_CNT, 32'd16);

    // Single candidate 0, plus saturation in the narrow copy
    wb_write(A_END, 32'd0);
    wb_write(A_CTRL, 32'h1);
    busy_len(n);
    chk("one_busy", 32'(n), 32'd5);
    rd_chk("one_best_e", A_BE, 32'd14);
    rd_chk("one_best_seq", A_BS, 32'd0);
    rd_chk("one_count", A_CNT, 32'd1);
    wb_read(A_BE, r0, r1);
    chk("e3_best_e", r1, 32'd7);
    wb_read(A_STAT, r0, r1);
    chk("one_status", r0, 32'h2);
    chk("e3_status_ovf", r1, 32'hA);

    // Empty range with interrupt enabled
    wb_write(A_START, 32'd5);
    wb_write(A_END, 32'd2);
    wb_write(A_CTRL, 32'h5);
    chk("empty_done", 32'(la0[65]), 32'd1);
    chk("empty_busy", 32'(la0[64]), 32'd0);
    chk("empty_irq", 32'(irq0), 32'd1);
    rd_chk("empty_count", A_CNT, 32'd0);
    rd_chk("empty_best_e", A_BE, 32'hFFFF);
    rd_chk("empty_best_seq", A_BS, 32'd0);
    rd_chk("ctrl_ien", A_CTRL, 32'h4);

    // Abort after 12 busy cycles, with a second start issued mid-run
    wb_write(A_START, 32'd0);
    wb_write(A_END, 32'd15);
    wb_write(A_CTRL, 32'h5);
    wb_write(A_CTRL, 32'h5);
    repeat (8) @(negedge clk);
    wb_write(A_CTRL, 32'h2);
    chk("abort_busy", 32'(la0[64]), 32'd0);
    chk("abort_irq", 32'(irq0), 32'd0);
    rd_chk("abort_status", A_STAT, 32'h4);
    rd_chk("abort_count", A_CNT, 32'd2);
    rd_chk("abort_best_e", A_BE, 32'd2);
    rd_chk("abort_best_seq", A_BS, 32'd1);
    wb_write(A_CTRL, 32'h2);
    rd_chk("idle_abort", A_STAT, 32'h4);
    wb_write(A_CTRL, 32'h3);
    chk("start_abort_busy", 32'(la0[64]), 32'd0);
    rd_chk("start_abort_status", A_STAT, 32'h4);

    // Reset in the middle of a search
    wb_write(A_START, 32'd3);
    wb_write(A_CTRL, 32'h5);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 32'(la0[64]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_la_nonzero", 32'(la0 != '0), 32'd0);
    chk("mid_rst_irq", 32'(irq0), 32'd0);
    chk("mid_rst_ack", 32'(ack0), 32'd0);
    chk("mid_rst_dat", dat0, 32'd0);
    rd_chk("mid_rst_status", A_STAT, 32'h0);
    rd_chk("mid_rst_ctrl", A_CTRL, 32'h0);
    rd_chk("mid_rst_start", A_START, 32'h0);
    rd_chk("mid_rst_end", A_END, 32'h0);
    rd_chk("mid_rst_best_e", A_BE, 32'hFFFF);
    rd_chk("mid_rst_best_seq", A_BS, 32'h0);
    rd_chk("mid_rst_count", A_CNT, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/labs_search_wb.md
LABS_SEARCH_WB -- requirements
Module: labs_search_wb

Interface
REQ-001 Parameter SEQ_WIDTH, default 16, candidate sequence length L in bits; legal range 3..32.
REQ-002 Parameter E_WIDTH, default 16, energy accumulator width; legal range 2..32.
REQ-003 wb_clk_i  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 wb_rst_i  in  1  reset; synchronous, active-high.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle, write-enable.
REQ-006 wbs_sel_i  in  4  byte selects; ignored, all writes are full-word.
REQ-007 wbs_adr_i  in  32  byte address; only adr[4:2] decoded, adr[31:5] and adr[1:0] ignored.
REQ-008 wbs_dat_i  in  32  write data; wbs_dat_o  out  32  read data.
REQ-009 wbs_ack_o  out  1  transfer acknowledge.
REQ-010 la_data_in, la_oenb  in  128 each  unused; la_data_out  out  128  debug probe.
REQ-011 irq  out  3  irq[0] = search-complete interrupt; irq[2:1] tied 0.

Function
REQ-012 Ack: wbs_ack_o SHALL rise one cycle after stb&cyc seen with ack low, stay high exactly one cycle; one ack per transfer.
REQ-013 Register map (adr[4:2]): 0 CTRL, 1 STATUS, 2 SEQ_START, 3 SEQ_END, 4 BEST_E, 5 BEST_SEQ, 6 COUNT, 7 reserved (reads 0, writes ignored).
REQ-014 CTRL write: bit0 start (self-clearing), bit1 abort (self-clearing), bit2 IEN (stored); CTRL read returns {29'b0, IEN, 2'b0}.
REQ-015 STATUS read: bit0 busy, bit1 done, bit2 aborted, bit3 overflow; writes ignored.
REQ-016 SEQ_START/SEQ_END: R/W, low SEQ_WIDTH bits stored, upper bits read 0; latched into the engine on start, so writes during busy do not affect the running search.
REQ-017 BEST_E, BEST_SEQ, COUNT read-only; unused upper bits read 0.
REQ-018 Sequence mapping: bit i of candidate value gives s_i = +1 if 1, -1 if 0, i = 0..L-1.
REQ-019 Per k in 1..L-1: C_k = (L-k) - 2*popcount(s[L-1-k:0] XOR s[L-1:k]); E = sum of C_k^2.
REQ-020 E accumulation saturates at 2^E_WIDTH-1; any saturation sets STATUS.overflow (sticky until next start).
REQ-021 FSM states IDLE, LOAD, CORR, CMP, DONE; IDLE is reset state.
REQ-022 IDLE: start -> LOAD with cur=SEQ_START, BEST_E=all-ones, BEST_SEQ=0, COUNT=0, done/aborted/overflow cleared; if SEQ_START > SEQ_END go straight to DONE instead.
REQ-023 LOAD (1 cycle): latch cur, clear accumulator, k=1 -> CORR.
REQ-024 CORR: one k per cycle, L-1 cycles -> CMP.
REQ-025 CMP (1 cycle): COUNT+1; if E < BEST_E (strict, earliest wins ties) update BEST_E/BEST_SEQ; if cur==SEQ_END -> DONE else cur+1 -> LOAD; cur never wraps.
REQ-026 Throughput: exactly L+1 cycles per candidate; busy high for (L+1)*(SEQ_END-SEQ_START+1) cycles.
REQ-027 DONE: set done, clear busy, return to IDLE next cycle; done holds until next start.
REQ-028 busy = state not IDLE/DONE; start while busy ignored.
REQ-029 Abort while busy: -> IDLE next cycle, aborted=1, done=0, BEST_E/BEST_SEQ/COUNT hold partial results; abort when idle ignored.
REQ-030 Start and abort in the same write: abort wins (if idle, nothing happens).
REQ-031 irq[0] = done & IEN, level.
REQ-032 la_data_out[31:0] = cur (zero-extended), [64] busy, [65] done, all other bits 0.

Reset
REQ-033 On wb_rst_i: state IDLE; wbs_ack_o 0, wbs_dat_o 0, irq 0, la_data_out 0; IEN, SEQ_START, SEQ_END, COUNT, BEST_SEQ, cur 0; BEST_E all-ones; all status flags 0; reset mid-search abandons it without setting done or aborted.

Verification (SEQ_WIDTH=4, E_WIDTH=16 unless stated)
REQ-034 START=0, END=15, start -> busy 80 cycles, done=1, BEST_E=2, BEST_SEQ=1, COUNT=16, overflow=0.
REQ-035 START=END=0 -> busy 5 cycles, BEST_E=14, BEST_SEQ=0, COUNT=1.
REQ-036 START=5, END=2 -> done next cycle, COUNT=0, BEST_E=0xFFFF, BEST_SEQ=0; with IEN=1 irq[0]=1.
REQ-037 START=0, END=15, abort after 12 busy cycles -> aborted=1, done=0, COUNT=2, BEST_E=2, BEST_SEQ=1; second start mid-run ignored.
REQ-038 E_WIDTH=3, START=END=0 -> BEST_E=7, overflow=1.
REQ-039 wb_rst_i pulsed mid-search -> all outputs/registers at REQ-033 values next cycle, busy=0.
